// File: rtl/ultrasonic_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// ultrasonic_scan_scheduler_if
// Purpose : result bus from the ultrasonic scan scheduler to its consumers
//           (tone generator frequency calculation, LED bar, ...).
// Signals :
//   result          CNT_W  echo high width in clock cycles, all-ones on timeout
//   result_id       ID_W   sensor index that result belongs to
//   result_valid    1      one-cycle strobe, one per scanned slot
//   result_timeout  1      qualifies result_valid: no complete echo in window
// Modports: master = scheduler (drives), slave = consumer (samples).
// ---------------------------------------------------------------------------
interface ultrasonic_scan_scheduler_if #(
    parameter int CNT_W = 24,
    parameter int ID_W  = 2
);
    logic [CNT_W-1:0] result;
    logic [ID_W-1:0]  result_id;
    logic             result_valid;
    logic             result_timeout;

    modport master (
        output result,
        output result_id,
        output result_valid,
        output result_timeout
    );

    modport slave (
        input result,
        input result_id,
        input result_valid,
        input result_timeout
    );
endinterface

// File: rtl/ultrasonic_scan_scheduler.sv
// ---------------------------------------------------------------------------
// ultrasonic_scan_scheduler
// Purpose : time-shares NUM_SENSORS HC-SR04 style rangers round-robin. Each
//           slot fires one trigger pulse, measures the synchronized echo
//           high width in clock cycles and reports it on the result bus.
//           Slots are PERIOD_CYCLES long, TR rise to next TR rise.
// Ports   :
//   i_clock   in   system clock, all logic on posedge
//   i_reset   in   synchronous, active-high
//   i_enable  in   keep scanning; sampled only in IDLE and at slot end
//   i_mask    in   (ULTRASONIC_MASK_EN only) per-sensor scan enable
//   i_ech     in   asynchronous echo inputs, one per sensor
//   o_tr      out  trigger outputs, never more than one bit high
//   o_busy    out  high in every state except IDLE
//   res_if    master modport of ultrasonic_scan_scheduler_if
// Configuration macro: ULTRASONIC_MASK_EN
//   defined     : adds i_mask; masked sensors are skipped entirely (no TR,
//                 no result, no slot time); all-zero mask behaves as
//                 i_enable=0.
//   not defined : every index 0..NUM_SENSORS-1 is scanned in order.
// ---------------------------------------------------------------------------
module ultrasonic_scan_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int PERIOD_CYCLES  = 5000000,
    parameter int CNT_W          = 24
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
`ifdef ULTRASONIC_MASK_EN
    input  logic [NUM_SENSORS-1:0]     i_mask,
`endif
    input  logic [NUM_SENSORS-1:0]     i_ech,
    output logic [NUM_SENSORS-1:0]     o_tr,
    output logic                       o_busy,
    ultrasonic_scan_scheduler_if.master res_if
);
    localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TRIG_CYCLES + TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_SENSORS-1:0] r_ech_meta;
    logic [NUM_SENSORS-1:0] r_ech_sync;
    logic                   r_ech_prev;
    logic [CNT_W-1:0]       r_slot_cnt;
    logic [CNT_W-1:0]       r_width;
    logic [ID_W-1:0]        r_slot;
    logic [CNT_W-1:0]       r_result;
    logic [ID_W-1:0]        r_result_id;
    logic                   r_result_valid;
    logic                   r_result_timeout;

    logic                   w_ech_s;
    logic                   w_rise;
    logic                   w_timeout;
    logic                   w_trig_end;
    logic                   w_period_end;
    logic                   w_go;
    logic [ID_W-1:0]        w_wrap_slot;
    logic [ID_W-1:0]        w_start_slot;
    logic [ID_W-1:0]        w_adv_slot;

    // Only the echo of the sensor owning the current slot matters.
    assign w_ech_s      = r_ech_sync[r_slot];
    // r_ech_prev tracks this sensor during TRIG as well, so an echo already
    // high when TR falls never looks like a rising edge.
    assign w_rise       = w_ech_s & ~r_ech_prev;
    assign w_timeout    = ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) &&
                          (r_slot_cnt == TMO_CNT);
    assign w_trig_end   = (r_state == S_TRIG) && (r_slot_cnt == TRIG_LAST);
    assign w_period_end = (r_state == S_HOLDOFF) && (r_slot_cnt == PER_LAST);
    assign w_wrap_slot  = (r_slot == LAST_ID) ? '0 : r_slot + 1'b1;

`ifdef ULTRASONIC_MASK_EN
    // First index at or after base (wrapping) whose mask bit is set; returns
    // base when the mask is empty (the caller then goes idle anyway).
    function automatic logic [ID_W-1:0] pick_slot(input logic [ID_W-1:0] base,
                                                  input logic [NUM_SENSORS-1:0] mask);
        logic [NUM_SENSORS-1:0] rot;
        logic [ID_W:0]          sum;
        logic                   found;
        rot       = NUM_SENSORS'({mask, mask} >> base);
        sum       = '0;
        found     = 1'b0;
        pick_slot = base;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_SENSORS))
                    sum = sum - (ID_W+1)'(NUM_SENSORS);
                pick_slot = sum[ID_W-1:0];
            end
        end
    endfunction

    assign w_go         = i_enable & (|i_mask);
    assign w_start_slot = pick_slot(r_slot, i_mask);
    assign w_adv_slot   = pick_slot(w_wrap_slot, i_mask);
`else
    assign w_go         = i_enable;
    assign w_start_slot = r_slot;
    assign w_adv_slot   = w_wrap_slot;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_go) w_state_next = S_TRIG;
            S_TRIG:      if (w_trig_end) w_state_next = S_WAIT_RISE;
            S_WAIT_RISE: begin
                // Timeout takes priority over any echo activity on the same cycle.
                if (w_timeout)   w_state_next = S_HOLDOFF;
                else if (w_rise) w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (w_timeout || !w_ech_s) w_state_next = S_HOLDOFF;
            end
            S_HOLDOFF:   if (w_period_end) w_state_next = w_go ? S_TRIG : S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_tr = '0;
        if (r_state == S_TRIG) o_tr[r_slot] = 1'b1;
        o_busy = (r_state != S_IDLE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ech_meta       <= '0;
            r_ech_sync       <= '0;
            r_ech_prev       <= 1'b0;
            r_slot_cnt       <= '0;
            r_width          <= '0;
            r_slot           <= '0;
            r_result         <= '0;
            r_result_id      <= '0;
            r_result_valid   <= 1'b0;
            r_result_timeout <= 1'b0;
        end else begin
            r_ech_meta     <= i_ech;
            r_ech_sync     <= r_ech_meta;
            r_ech_prev     <= w_ech_s;
            r_result_valid <= 1'b0;

            // Slot counter restarts on every TR rise so the period stays exact.
            if (w_state_next == S_TRIG && r_state != S_TRIG)
                r_slot_cnt <= '0;
            else if (r_state != S_IDLE)
                r_slot_cnt <= r_slot_cnt + 1'b1;

            if (r_state == S_IDLE && w_go)
                r_slot <= w_start_slot;
            else if (w_period_end)
                r_slot <= w_adv_slot;

            if (r_state == S_WAIT_RISE && w_rise)
                r_width <= CNT_W'(1);
            else if (r_state == S_MEASURE && w_ech_s && r_width != '1)
                r_width <= r_width + 1'b1;

            if (w_timeout) begin
                r_result         <= '1;
                r_result_id      <= r_slot;
                r_result_timeout <= 1'b1;
                r_result_valid   <= 1'b1;
            end else if (r_state == S_MEASURE && !w_ech_s) begin
                r_result         <= r_width;
                r_result_id      <= r_slot;
                r_result_timeout <= 1'b0;
                r_result_valid   <= 1'b1;
            end
        end
    end

    assign res_if.result         = r_result;
    assign res_if.result_id      = r_result_id;
    assign res_if.result_valid   = r_result_valid;
    assign res_if.result_timeout = r_result_timeout;

endmodule
